dc_wr_fifo: RTL and testbench



---
 rtl/dc_wr_fifo.sv | 139 +++++++++++++
 tb/tb_dc_wr_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_wr_fifo.sv
// Store write buffer in front of the data cache: in-order store queue with line-overlap conflict detect.
// Optional macro DC_WR_FIFO_HWM_EN adds the wr_fifo_hwm high-water-mark output.

module dc_wr_fifo_lines (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic [27:0] o_l0,
    output logic [27:0] o_l1
);
    logic [4:0] w_end;

    // Offset plus byte count past 16 means the access spills into the next line.
    assign w_end = {1'b0, i_addr[3:0]} + (5'd1 << i_size);
    assign o_l0  = i_addr[31:4];
    assign o_l1  = (w_end > 5'd16) ? o_l0 + 28'd1 : o_l0;
endmodule

module dc_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_wr_valid,
    input  logic [31:0]       wb_wr_addr,
    input  logic [63:0]       wb_wr_data,
    input  logic [1:0]        wb_wr_size,
    input  logic              mem_wr_done,
    input  logic [31:0]       mem_rd_addr,
    input  logic [1:0]        mem_rd_size,
    input  logic              v_mem_read,
    output logic [31:0]       mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic [1:0]        mem_wr_size,
    output logic              wr_fifo_empty,
    output logic              wr_fifo_to_be_full,
    output logic              wr_fifo_full,
    output logic              mem_conflict,
    output logic              wr_fifo_ovf
`ifdef DC_WR_FIFO_HWM_EN
    , output logic [PTR_W:0]  wr_fifo_hwm
`endif
);
    logic [PTR_W-1:0]             r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]               r_count;
    logic [DEPTH-1:0]             r_vld;
    logic [DEPTH-1:0][31:0]       r_addr;
    logic [DEPTH-1:0][63:0]       r_data;
    logic [DEPTH-1:0][1:0]        r_size;
    logic                         r_ovf;

    logic                         w_empty, w_full, w_push, w_pop;
    logic [PTR_W:0]               w_cnt_nxt;
    logic [27:0]                  w_rl0, w_rl1;
    logic [DEPTH-1:0][27:0]       w_wl0, w_wl1;
    logic [DEPTH-1:0]             w_hit;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop   = mem_wr_done && !w_empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_push  = wb_wr_valid && (!w_full || w_pop);

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_pop)      w_cnt_nxt = r_count + 1'b1;
        else if (w_pop && !w_push) w_cnt_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            // Push after pop: at full both pointers alias and the new entry must stay valid.
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (wb_wr_valid && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= wb_wr_addr;
            r_data[r_wr_ptr] <= wb_wr_data;
            r_size[r_wr_ptr] <= wb_wr_size;
        end
    end

    assign mem_wr_addr        = w_empty ? '0 : r_addr[r_rd_ptr];
    assign mem_wr_data        = w_empty ? '0 : r_data[r_rd_ptr];
    assign mem_wr_size        = w_empty ? '0 : r_size[r_rd_ptr];
    assign wr_fifo_empty      = w_empty;
    assign wr_fifo_full       = w_full;
    assign wr_fifo_to_be_full = (r_count >= (PTR_W+1)'(DEPTH-1));
    assign wr_fifo_ovf        = r_ovf;

    dc_wr_fifo_lines u_rd_lines (
        .i_addr (mem_rd_addr),
        .i_size (mem_rd_size),
        .o_l0   (w_rl0),
        .o_l1   (w_rl1)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        dc_wr_fifo_lines u_wr_lines (
            .i_addr (r_addr[g]),
            .i_size (r_size[g]),
            .o_l0   (w_wl0[g]),
            .o_l1   (w_wl1[g])
        );
        assign w_hit[g] = r_vld[g] &&
                          ((w_rl0 == w_wl0[g]) || (w_rl0 == w_wl1[g]) ||
                           (w_rl1 == w_wl0[g]) || (w_rl1 == w_wl1[g]));
    end

    assign mem_conflict = v_mem_read && (|w_hit);

`ifdef DC_WR_FIFO_HWM_EN
    logic [PTR_W:0] r_hwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_hwm <= '0;
        else if (w_cnt_nxt > r_hwm) r_hwm <= w_cnt_nxt;
    end

    assign wr_fifo_hwm = r_hwm;
`endif
endmodule

// File: tb/tb_dc_wr_fifo.sv
// Bench for dc_wr_fifo: directed plan steps plus random traffic against a queue-based byte-range model.
module tb_dc_wr_fifo;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_wr_valid = 1'b0;
    logic [31:0] wb_wr_addr = '0;
    logic [63:0] wb_wr_data = '0;
    logic [1:0]  wb_wr_size = '0;
    logic        mem_wr_done = 1'b0;
    logic [31:0] mem_rd_addr = '0;
    logic [1:0]  mem_rd_size = '0;
    logic        v_mem_read = 1'b0;
    logic [31:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [1:0]  mem_wr_size;
    logic        wr_fifo_empty, wr_fifo_to_be_full, wr_fifo_full, mem_conflict, wr_fifo_ovf;
`ifdef DC_WR_FIFO_HWM_EN
    logic [PTR_W:0] wr_fifo_hwm;
`endif

    dc_wr_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_wr_valid(wb_wr_valid), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .wb_wr_size(wb_wr_size), .mem_wr_done(mem_wr_done),
        .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size), .v_mem_read(v_mem_read),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_size(mem_wr_size),
        .wr_fifo_empty(wr_fifo_empty), .wr_fifo_to_be_full(wr_fifo_to_be_full),
        .wr_fifo_full(wr_fifo_full), .mem_conflict(mem_conflict), .wr_fifo_ovf(wr_fifo_ovf)
`ifdef DC_WR_FIFO_HWM_EN
        , .wr_fifo_hwm(wr_fifo_hwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
        logic [1:0]  s;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   m_hwm;
    int   n_chk;
    int   n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Two accesses conflict if the sets of 16-byte lines their byte ranges touch intersect.
    function automatic bit overlap(logic [31:0] ra, logic [1:0] rs, logic [31:0] wa, logic [1:0] ws);
        logic [31:0] re, we;
        re = ra + (32'd1 << rs) - 32'd1;
        we = wa + (32'd1 << ws) - 32'd1;
        return (ra[31:4] == wa[31:4]) || (ra[31:4] == we[31:4]) ||
               (re[31:4] == wa[31:4]) || (re[31:4] == we[31:4]);
    endfunction

    task automatic check_all(input string tag);
        bit exp_conf;
        exp_conf = 1'b0;
        if (v_mem_read)
            foreach (q[i]) if (overlap(mem_rd_addr, mem_rd_size, q[i].a, q[i].s)) exp_conf = 1'b1;
        chk({tag, ".empty"}, 64'(wr_fifo_empty), 64'(q.size() == 0));
        chk({tag, ".tbf"},   64'(wr_fifo_to_be_full), 64'(q.size() >= DEPTH - 1));
        chk({tag, ".full"},  64'(wr_fifo_full), 64'(q.size() == DEPTH));
        chk({tag, ".ovf"},   64'(wr_fifo_ovf), 64'(m_ovf));
        chk({tag, ".conf"},  64'(mem_conflict), 64'(exp_conf));
        chk({tag, ".haddr"}, 64'(mem_wr_addr), (q.size() == 0) ? 64'd0 : 64'(q[0].a));
        chk({tag, ".hdata"}, mem_wr_data, (q.size() == 0) ? 64'd0 : q[0].d);
        chk({tag, ".hsize"}, 64'(mem_wr_size), (q.size() == 0) ? 64'd0 : 64'(q[0].s));
`ifdef DC_WR_FIFO_HWM_EN
        chk({tag, ".hwm"},   64'(wr_fifo_hwm), 64'(m_hwm));
`endif
    endtask

    // Inputs are already driven; update the model from the pre-edge state, then clock.
    task automatic step(input string tag);
        bit pop, push;
        pop  = mem_wr_done && (q.size() != 0);
        push = wb_wr_valid && ((q.size() < DEPTH) || pop);
        if (wb_wr_valid && (q.size() == DEPTH) && !pop) m_ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{a: wb_wr_addr, d: wb_wr_data, s: wb_wr_size});
        if (q.size() > m_hwm) m_hwm = q.size();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit push, input logic [31:0] a, input logic [63:0] d,
                         input logic [1:0] s, input bit done);
        wb_wr_valid = push;
        wb_wr_addr  = a;
        wb_wr_data  = d;
        wb_wr_size  = s;
        mem_wr_done = done;
    endtask

    // Pulses reset between clock edges; outputs must drop while reset is still low.
    task automatic pulse_reset(input string tag);
        drive(1'b0, '0, '0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_hwm = 0;
        #1;
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        m_ovf  = 1'b0;
        m_hwm  = 0;

        // Reset state
        #3;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h1000 + 32'(8 * k), 64'(k), 2'd3, 1'b0);
            step("fill");
            if (k == 5) chk("fill.tbf_after6", 64'(wr_fifo_to_be_full), 64'd0);
            if (k == 6) chk("fill.tbf_after7", 64'(wr_fifo_to_be_full), 64'd1);
            if (k == 6) chk("fill.full_after7", 64'(wr_fifo_full), 64'd0);
            if (k == 7) chk("fill.full_after8", 64'(wr_fifo_full), 64'd1);
        end
        chk("fill.head_addr", 64'(mem_wr_addr), 64'h1000);
        chk("fill.head_data", mem_wr_data, 64'd0);
        drive(1'b1, 32'h1111_0000, 64'hdead, 2'd0, 1'b0);
        step("ovf");
        chk("ovf.flag", 64'(wr_fifo_ovf), 64'd1);
        chk("ovf.head", 64'(mem_wr_addr), 64'h1000);

        // Drain order
        for (int k = 0; k < 8; k++) begin
            chk("drain.head", 64'(mem_wr_addr), 64'h1000 + 64'(8 * k));
            drive(1'b0, '0, '0, '0, 1'b1);
            step("drain");
        end
        chk("drain.empty", 64'(wr_fifo_empty), 64'd1);
        chk("drain.head0", 64'(mem_wr_addr), 64'd0);
        step("drain.extra");
        chk("drain.extra_empty", 64'(wr_fifo_empty), 64'd1);
        drive(1'b1, 32'h0000_0500, 64'h55, 2'd1, 1'b0);
        step("drain.after");
        chk("drain.one_entry_not_tbf", 64'(wr_fifo_to_be_full), 64'd0);

        // Simultaneous push/pop at full
        pulse_reset("rst2");
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h1000 + 32'(8 * k), 64'(k), 2'd3, 1'b0);
            step("sfill");
        end
        drive(1'b1, 32'h2000, 64'h2000, 2'd2, 1'b1);
        step("simul");
        chk("simul.full", 64'(wr_fifo_full), 64'd1);
        chk("simul.ovf", 64'(wr_fifo_ovf), 64'd0);
        for (int k = 1; k < 8; k++) begin
            drive(1'b0, '0, '0, '0, 1'b1);
            step("spop");
        end
        chk("simul.head2000", 64'(mem_wr_addr), 64'h2000);
        // Push and pop together with a single entry: count stays 1
        drive(1'b1, 32'h2100, 64'h21, 2'd0, 1'b1);
        step("simul1");
        chk("simul1.head", 64'(mem_wr_addr), 64'h2100);

        // Conflict line crossing
        pulse_reset("rst3");
        drive(1'b1, 32'h300E, 64'h3, 2'd2, 1'b0);
        step("cpush");
        drive(1'b0, '0, '0, '0, 1'b0);
        mem_rd_addr = 32'h3010; mem_rd_size = 2'd0; v_mem_read = 1'b1;
        #1;
        chk("conf.cross", 64'(mem_conflict), 64'd1);
        mem_rd_addr = 32'h3020;
        #1;
        chk("conf.miss", 64'(mem_conflict), 64'd0);
        mem_rd_addr = 32'h3010; v_mem_read = 1'b0;
        #1;
        chk("conf.novalid", 64'(mem_conflict), 64'd0);
        v_mem_read = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b1);
        step("conf.pop");
        chk("conf.popped", 64'(mem_conflict), 64'd0);
        v_mem_read = 1'b0;

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h3800 + 32'(16 * k), 64'(k), 2'd1, 1'b0);
            step("rpush");
        end
        pulse_reset("rst4");
        chk("rst4.empty", 64'(wr_fifo_empty), 64'd1);
        drive(1'b1, 32'h4000, 64'h40, 2'd3, 1'b0);
        step("r4000");
        chk("rst4.head4000", 64'(mem_wr_addr), 64'h4000);

`ifdef DC_WR_FIFO_HWM_EN
        pulse_reset("rst5");
        for (int k = 0; k < 5; k++) begin drive(1'b1, 32'h5000 + 32'(k), 64'(k), 2'd0, 1'b0); step("hpush"); end
        for (int k = 0; k < 5; k++) begin drive(1'b0, '0, '0, '0, 1'b1); step("hpop"); end
        for (int k = 0; k < 2; k++) begin drive(1'b1, 32'h5100 + 32'(k), 64'(k), 2'd0, 1'b0); step("hpush2"); end
        chk("hwm.five", 64'(wr_fifo_hwm), 64'd5);
`endif

        // Random traffic; phases bias toward filling or draining to reach both ends
        pulse_reset("rst6");
        for (int c = 0; c < 600; c++) begin
            int pp;
            logic [31:0] a;
            pp = ((c / 60) % 2 == 0) ? 80 : 30;
            a  = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : (32'h6000 + 32'($urandom_range(0, 95)));
            drive($urandom_range(0, 99) < pp, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 55);
            mem_rd_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                      : (32'h6000 + 32'($urandom_range(0, 111)));
            mem_rd_size = 2'($urandom_range(0, 3));
            v_mem_read  = $urandom_range(0, 3) != 0;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
